// File: rtl/wasm_prog_loader_if.sv
// Program byte stream and instruction BRAM write port of the WASM program loader.
// Stream handshake: a byte moves on every rising clock edge where s_valid and
// s_ready are both high; s_last is meaningful only when s_valid is high, and the
// producer keeps s_data/s_last steady until that byte has been taken.
interface wasm_prog_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_last;
    logic              s_ready;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;

    // Loader side: consumes the stream, drives the BRAM write port
    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, o_mem_we, o_mem_addr, o_mem_wdata
    );

    // Producer / memory side
    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/wasm_prog_loader.sv
// WASM program loader: checks the 4-byte wasm magic, streams the program body
// into instruction BRAM, releases the core from reset, then records how the run
// ended (result code) and how many core cycles it took.
module wasm_prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    wasm_prog_loader_if.slave   bus,
    output logic                o_cpu_rst_n,
    input  logic                i_cpu_finish,
    input  logic                i_instr_error,
    input  logic                i_stack_exceed,
    input  logic                i_stack_empty_pop,
    output logic                o_busy,
    output logic                o_done,
    output logic [2:0]          o_err_code,
    output logic [31:0]         o_cycle_cnt,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAGIC = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [31:0]       TMO_LAST  = 32'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [2:0]        code_q, code_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              accept;
    logic [7:0]        magic_exp;

    // Expected magic byte for the current position in the header
    always_comb begin
        magic_exp = 8'h00;
        case (idx_q)
            2'd0:    magic_exp = 8'h00;
            2'd1:    magic_exp = 8'h61;
            2'd2:    magic_exp = 8'h73;
            default: magic_exp = 8'h6D;
        endcase
    end

    // Next-state, counters and all registered outputs
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_cnt_d = addr_cnt_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        accept     = bus.s_valid & s_ready_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d    = ST_MAGIC;
                    idx_d      = 2'd0;
                    addr_cnt_d = '0;
                    code_d     = 3'd0;
                    cnt_d      = 32'd0;
                end
            end
            ST_MAGIC: begin
                if (accept) begin
                    if (bus.s_data != magic_exp) begin
                        state_d = ST_DONE;
                        code_d  = 3'd1;
                    end else if (bus.s_last) begin
                        // Header ended before any program body
                        state_d = ST_DONE;
                        code_d  = 3'd7;
                    end else if (idx_q == 2'd3) begin
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    maddr_d = addr_cnt_q;
                    wdata_d = bus.s_data;
                    if (bus.s_last) begin
                        state_d = ST_RUN;
                        cnt_d   = 32'd0;
                    end else if (addr_cnt_q == ADDR_LAST) begin
                        // BRAM full and more bytes pending: stop without wrapping
                        state_d = ST_DONE;
                        code_d  = 3'd2;
                    end else begin
                        addr_cnt_d = addr_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_instr_error) begin
                    state_d = ST_DONE;
                    code_d  = 3'd3;
                end else if (i_stack_exceed) begin
                    state_d = ST_DONE;
                    code_d  = 3'd4;
                end else if (i_stack_empty_pop) begin
                    state_d = ST_DONE;
                    code_d  = 3'd5;
                end else if (i_cpu_finish) begin
                    state_d = ST_DONE;
                    code_d  = 3'd0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    code_d  = 3'd6;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d   = (state_d == ST_MAGIC) || (state_d == ST_LOAD);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        cpu_rst_n_d = (state_d == ST_RUN);
    end

    // State and output registers; reset also drops any pending BRAM write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            addr_cnt_q  <= '0;
            code_q      <= 3'd0;
            cnt_q       <= 32'd0;
            we_q        <= 1'b0;
            maddr_q     <= '0;
            wdata_q     <= 8'h00;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_cnt_q  <= addr_cnt_d;
            code_q      <= code_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            maddr_q     <= maddr_d;
            wdata_q     <= wdata_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.o_mem_we    = we_q;
    assign bus.o_mem_addr  = maddr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign o_cpu_rst_n     = cpu_rst_n_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err_code      = code_q;
    assign o_cycle_cnt     = cnt_q;
    assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_wasm_prog_loader.sv
// Self-checking bench for wasm_prog_loader (ADDR_W=3, TIMEOUT=20).
module tb_wasm_prog_loader;

    localparam int AW  = 3;
    localparam int TMO = 20;
    localparam int W   = AW + 8;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        o_cpu_rst_n;
    logic        i_cpu_finish, i_instr_error, i_stack_exceed, i_stack_empty_pop;
    logic        o_busy, o_done;
    logic [2:0]  o_err_code;
    logic [31:0] o_cycle_cnt;
    logic [2:0]  o_dbg_state;

    wasm_prog_loader_if #(.ADDR_W(AW)) bus ();

    wasm_prog_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (i_start),
        .bus               (bus),
        .o_cpu_rst_n       (o_cpu_rst_n),
        .i_cpu_finish      (i_cpu_finish),
        .i_instr_error     (i_instr_error),
        .i_stack_exceed    (i_stack_exceed),
        .i_stack_empty_pop (i_stack_empty_pop),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err_code        (o_err_code),
        .o_cycle_cnt       (o_cycle_cnt),
        .o_dbg_state       (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           run_cycles;
    bit           saw_cpu_on;

    bit ev_err[64];
    bit ev_exc[64];
    bit ev_emp[64];
    bit ev_fin[64];

    // Observe BRAM writes and core-release cycles away from the active edge
    always @(negedge clk) begin
        if (bus.o_mem_we === 1'b1) got_q.push_back({bus.o_mem_addr, bus.o_mem_wdata});
        if (o_cpu_rst_n === 1'b1) begin
            run_cycles++;
            saw_cpu_on = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    // Walks the byte list by the header/body/overflow rules, then the event
    // schedule by priority; fills exp_q with the BRAM writes it predicts.
    task automatic model(input logic [7:0] b[$], input bit last_flag,
                         output logic [2:0] code, output int cnt, output bit runs);
        logic [7:0] magic[4] = '{8'h00, 8'h61, 8'h73, 8'h6D};
        int addr;
        bit lst;
        addr = 0;
        code = 3'd0;
        cnt  = 0;
        runs = 1'b0;
        exp_q.delete();
        for (int k = 0; k < b.size(); k++) begin
            lst = last_flag && (k == b.size() - 1);
            if (k < 4) begin
                if (b[k] != magic[k]) begin code = 3'd1; return; end
                if (lst) begin code = 3'd7; return; end
            end else begin
                exp_q.push_back({addr[AW-1:0], b[k]});
                if (lst) begin runs = 1'b1; break; end
                if (addr == (1 << AW) - 1) begin code = 3'd2; return; end
                addr++;
            end
        end
        if (!runs) return;
        for (int c = 0; c < TMO; c++) begin
            cnt = c;
            if (ev_err[c])        begin code = 3'd3; return; end
            else if (ev_exc[c])   begin code = 3'd4; return; end
            else if (ev_emp[c])   begin code = 3'd5; return; end
            else if (ev_fin[c])   begin code = 3'd0; return; end
            else if (c == TMO - 1) begin code = 3'd6; return; end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_events();
        for (int c = 0; c < 64; c++) begin
            ev_err[c] = 1'b0; ev_exc[c] = 1'b0; ev_emp[c] = 1'b0; ev_fin[c] = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Presents bytes in order; stops early once the loader reports done
    task automatic drive_stream(input logic [7:0] b[$], input bit last_flag, input bit rnd,
                                input int max_acc, output int n_acc);
        int guard;
        guard = 0;
        n_acc = 0;
        while (n_acc < b.size() && n_acc < max_acc) begin
            @(posedge clk); #1;
            bus.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data  = b[n_acc];
            bus.s_last  = last_flag && (n_acc == b.size() - 1);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) n_acc++;
            else if (o_done) break;
            guard++;
            if (guard > 2000) begin
                checks++; errors++;
                $display("FAIL stream_timeout: accepted=%0d required=%0d", n_acc, b.size());
                break;
            end
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Plays ev_* onto the core status inputs, one entry per RUN cycle
    task automatic drive_events();
        int c;
        int guard;
        c = 0;
        guard = 0;
        @(negedge clk);
        while (o_cpu_rst_n !== 1'b1) begin
            if (guard > 50) begin
                checks++; errors++;
                $display("FAIL run_entry_timeout: o_cpu_rst_n=%b required=1", o_cpu_rst_n);
                return;
            end
            @(negedge clk);
            guard++;
        end
        while (o_cpu_rst_n === 1'b1 && c < 64) begin
            i_instr_error     = ev_err[c];
            i_stack_exceed    = ev_exc[c];
            i_stack_empty_pop = ev_emp[c];
            i_cpu_finish      = ev_fin[c];
            @(negedge clk);
            c++;
        end
        i_instr_error = 1'b0; i_stack_exceed = 1'b0; i_stack_empty_pop = 1'b0; i_cpu_finish = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (o_done !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (o_done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: o_done=%b required=1", o_done);
        end
        #1;
    endtask

    // One complete start/load/run sequence checked against the model
    task automatic run_scenario(input string name, input logic [7:0] b[$], input bit last_flag,
                                input bit rnd, output int n_acc);
        logic [2:0] e_code;
        int         e_cnt;
        bit         runs;
        model(b, last_flag, e_code, e_cnt, runs);
        got_q.delete();
        run_cycles = 0;
        saw_cpu_on = 1'b0;
        pulse_start();
        drive_stream(b, last_flag, rnd, 1000, n_acc);
        if (runs) drive_events();
        wait_done();
        checks++;
        if (o_err_code !== e_code) begin
            errors++;
            $display("FAIL %s code: got=%0d exp=%0d", name, o_err_code, e_code);
        end
        checks++;
        if (o_cycle_cnt !== 32'(e_cnt)) begin
            errors++;
            $display("FAIL %s cycle_cnt: got=%0d exp=%0d", name, o_cycle_cnt, e_cnt);
        end
        checks++;
        if (run_cycles != (runs ? e_cnt + 1 : 0)) begin
            errors++;
            $display("FAIL %s run_cycles: got=%0d exp=%0d", name, run_cycles, runs ? e_cnt + 1 : 0);
        end
        checks++;
        if (o_busy !== 1'b0 || o_cpu_rst_n !== 1'b0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_outputs: busy=%b cpu_rst_n=%b s_ready=%b exp=0,0,0",
                     name, o_busy, o_cpu_rst_n, bus.s_ready);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got addr=%0d data=%h exp addr=%0d data=%h", name, i,
                             got_q[i][W-1:8], got_q[i][7:0], exp_q[i][W-1:8], exp_q[i][7:0]);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.s_ready !== 1'b0 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== '0 ||
            bus.o_mem_wdata !== 8'h00 || o_cpu_rst_n !== 1'b0 || o_busy !== 1'b0 ||
            o_done !== 1'b0 || o_err_code !== 3'd0 || o_cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%0d wd=%h crst=%b busy=%b done=%b code=%0d cnt=%0d exp all 0",
                     bus.s_ready, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata, o_cpu_rst_n,
                     o_busy, o_done, o_err_code, o_cycle_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_dbg_state !== 3'd0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: state=%0d s_ready=%b exp 0,0", o_dbg_state, bus.s_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] b[$] = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h41, 8'h2A, 8'h0B};
        int n;
        clear_events();
        ev_fin[4] = 1'b1;
        run_scenario("basic", b, 1'b1, 1'b0, n);
        checks++;
        if (o_err_code !== 3'd0 || o_cycle_cnt !== 32'd4) begin
            errors++;
            $display("FAIL basic_const: code=%0d cnt=%0d exp 0,4", o_err_code, o_cycle_cnt);
        end
    endtask

    task automatic test_bad_magic();
        logic [7:0] b[$] = '{8'h00, 8'h61, 8'h74, 8'h6D, 8'h11, 8'h22};
        int n;
        clear_events();
        run_scenario("bad_magic", b, 1'b1, 1'b0, n);
        checks++;
        if (n != 3 || saw_cpu_on !== 1'b0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL bad_magic_stop: accepted=%0d cpu_on=%b writes=%0d exp 3,0,0",
                     n, saw_cpu_on, got_q.size());
        end
    endtask

    task automatic test_empty();
        logic [7:0] b4[$] = '{8'h00, 8'h61, 8'h73, 8'h6D};
        logic [7:0] b2[$] = '{8'h00, 8'h61};
        logic [7:0] bx[$] = '{8'h00, 8'h62};
        int n;
        clear_events();
        run_scenario("empty4", b4, 1'b1, 1'b0, n);
        run_scenario("empty2", b2, 1'b1, 1'b0, n);
        run_scenario("mismatch_last", bx, 1'b1, 1'b0, n);
    endtask

    task automatic test_overflow();
        logic [7:0] b[$];
        int n;
        b = '{8'h00, 8'h61, 8'h73, 8'h6D};
        for (int i = 0; i < 9; i++) b.push_back(8'(8'hA0 + i));
        clear_events();
        run_scenario("overflow", b, 1'b0, 1'b0, n);
        checks++;
        if (n != 12 || o_err_code !== 3'd2 || got_q.size() != 8) begin
            errors++;
            $display("FAIL overflow_stop: accepted=%0d code=%0d writes=%0d exp 12,2,8",
                     n, o_err_code, got_q.size());
        end
    endtask

    task automatic test_priority();
        logic [7:0] b[$] = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h02};
        logic [3:0] masks[5] = '{4'b0110, 4'b1111, 4'b0011, 4'b0001, 4'b1001};
        int n;
        for (int t = 0; t < 5; t++) begin
            clear_events();
            ev_err[3] = masks[t][3];
            ev_exc[3] = masks[t][2];
            ev_emp[3] = masks[t][1];
            ev_fin[3] = masks[t][0];
            run_scenario($sformatf("priority_%0d", t), b, 1'b1, 1'b0, n);
        end
        clear_events();
        ev_exc[2] = 1'b1;
        ev_fin[2] = 1'b1;
        run_scenario("exceed_finish", b, 1'b1, 1'b0, n);
        checks++;
        if (o_err_code !== 3'd4) begin
            errors++;
            $display("FAIL exceed_finish_const: code=%0d exp 4", o_err_code);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b[$] = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h55};
        int n;
        clear_events();
        run_scenario("timeout", b, 1'b1, 1'b0, n);
        checks++;
        if (o_err_code !== 3'd6 || o_cycle_cnt !== 32'd19 || run_cycles != 20) begin
            errors++;
            $display("FAIL timeout_const: code=%0d cnt=%0d run_cycles=%0d exp 6,19,20",
                     o_err_code, o_cycle_cnt, run_cycles);
        end
    endtask

    task automatic test_random();
        logic [7:0] b[$];
        int n;
        int c;
        int len;
        logic [3:0] m;
        for (int it = 0; it < 10; it++) begin
            b = '{8'h00, 8'h61, 8'h73, 8'h6D};
            if ($urandom_range(0, 4) == 0) b[$urandom_range(0, 3)] ^= 8'(1 << $urandom_range(0, 7));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            clear_events();
            c = $urandom_range(0, 24);
            m = 4'($urandom_range(0, 15));
            ev_err[c] = m[3]; ev_exc[c] = m[2]; ev_emp[c] = m[1]; ev_fin[c] = m[0];
            run_scenario($sformatf("random_%0d", it), b, 1'b1, 1'b1, n);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] b[$] = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h10, 8'h20, 8'h30, 8'h40};
        int n;
        clear_events();
        ev_fin[2] = 1'b1;
        got_q.delete();
        pulse_start();
        drive_stream(b, 1'b1, 1'b1, 6, n);
        checks++;
        if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 3'd1 || bus.o_mem_wdata !== 8'h20) begin
            errors++;
            $display("FAIL pending_write: we=%b addr=%0d data=%h exp 1,1,20",
                     bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b0 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== '0 ||
            bus.o_mem_wdata !== 8'h00 || o_cpu_rst_n !== 1'b0 || o_busy !== 1'b0 ||
            o_done !== 1'b0 || o_err_code !== 3'd0 || o_cycle_cnt !== 32'd0 || o_dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL midload_reset_outputs: rdy=%b we=%b addr=%0d busy=%b state=%0d exp all 0",
                     bus.s_ready, bus.o_mem_we, bus.o_mem_addr, o_busy, o_dbg_state);
        end
        got_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (got_q.size() != 0 || bus.s_ready !== 1'b0 || o_dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL after_release: writes=%0d s_ready=%b state=%0d exp 0,0,0",
                     got_q.size(), bus.s_ready, o_dbg_state);
        end
        run_scenario("rerun", b, 1'b1, 1'b1, n);
        checks++;
        if (o_err_code !== 3'd0 || o_cycle_cnt !== 32'd2) begin
            errors++;
            $display("FAIL rerun_const: code=%0d cnt=%0d exp 0,2", o_err_code, o_cycle_cnt);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        i_start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.s_last = 1'b0;
        i_cpu_finish = 1'b0;
        i_instr_error = 1'b0;
        i_stack_exceed = 1'b0;
        i_stack_empty_pop = 1'b0;
        run_cycles = 0;
        saw_cpu_on = 1'b0;
        clear_events();
        test_reset();
        test_basic();
        test_bad_magic();
        test_empty();
        test_overflow();
        test_priority();
        test_timeout();
        test_random();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wasm_prog_loader.md
WASM_PROG_LOADER -- requirements
Module: wasm_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10: instruction BRAM address width; depth is 2^ADDR_W bytes.
REQ-002 Parameter TIMEOUT, default 500: maximum RUN-state cycles before abort.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_start  input  1  single-cycle request to begin a load-and-run sequence.
REQ-006 s_valid  input  1  program byte stream valid.
REQ-007 s_data  input  8  program byte.
REQ-008 s_last  input  1  marks final byte of program; qualified by s_valid.
REQ-009 s_ready  output  1  loader accepts s_data this cycle.
REQ-010 o_mem_we  output  1  instruction BRAM write enable.
REQ-011 o_mem_addr  output  ADDR_W  instruction BRAM write address.
REQ-012 o_mem_wdata  output  8  instruction BRAM write data.
REQ-013 o_cpu_rst_n  output  1  active-low reset to the downstream WASM core.
REQ-014 i_cpu_finish  input  1  core reports program completion.
REQ-015 i_instr_error  input  1  core reports illegal instruction.
REQ-016 i_stack_exceed  input  1  core reports stack overflow.
REQ-017 i_stack_empty_pop  input  1  core reports pop from empty stack.
REQ-018 o_busy  output  1  high in LOAD and RUN.
REQ-019 o_done  output  1  high in DONE.
REQ-020 o_err_code  output  3  result code, valid while o_done=1.
REQ-021 o_cycle_cnt  output  32  core cycles counted in RUN.

Function
REQ-022 States: IDLE, MAGIC, LOAD, RUN, DONE; one-hot or encoded, implementer's choice.
REQ-023 IDLE: s_ready=0, o_cpu_rst_n=0; i_start -> MAGIC, byte index and address counter cleared.
REQ-024 A byte is accepted on any cycle with s_valid=1 and s_ready=1; s_ready=1 in MAGIC and LOAD only.
REQ-025 MAGIC: first four accepted bytes compared against 0x00,0x61,0x73,0x6D in order; these bytes are never written to BRAM.
REQ-026 MAGIC mismatch on any byte -> DONE, code 1; fourth byte matching with s_last=0 -> LOAD; s_last=1 on any magic byte -> DONE, code 7 (empty program), unless a mismatch on the same byte, which takes code 1.
REQ-027 LOAD: each accepted byte is written at the next address starting from 0; o_mem_we/o_mem_addr/o_mem_wdata are registered and asserted exactly one cycle after acceptance; o_mem_we=0 otherwise.
REQ-028 LOAD: accepted byte with s_last=1 -> RUN (its write still issues the following cycle).
REQ-029 LOAD: accepted byte at address 2^ADDR_W-1 with s_last=0 -> byte written, then DONE, code 2 (overflow); address counter does not wrap.
REQ-030 RUN: o_cpu_rst_n=1; o_cycle_cnt cleared on RUN entry and incremented each RUN cycle with no terminating event.
REQ-031 RUN termination priority, same-cycle events: i_instr_error (code 3) > i_stack_exceed (4) > i_stack_empty_pop (5) > i_cpu_finish (0) > timeout (6).
REQ-032 Timeout fires in the RUN cycle where o_cycle_cnt equals TIMEOUT-1 and no higher-priority event is present.
REQ-033 Any termination -> DONE the next cycle; o_cycle_cnt freezes at its value in the terminating cycle.
REQ-034 DONE: o_done=1, o_cpu_rst_n=0, s_ready=0; o_err_code and o_cycle_cnt held; i_start -> MAGIC, clearing code, count and counters.
REQ-035 i_start is ignored in MAGIC, LOAD and RUN; core status inputs are ignored outside RUN.
REQ-036 o_cpu_rst_n is registered and glitch-free.

Reset
REQ-037 rst_n low, any state: immediately IDLE, s_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_cpu_rst_n=0, o_busy=0, o_done=0, o_err_code=0, o_cycle_cnt=0.
REQ-038 Reset during LOAD discards the pending registered write; no BRAM write occurs in the cycle after reset release.

Verification
REQ-039 Start, stream 00 61 73 6D 41 2A 0B(last), finish pulse 5th RUN cycle -> BRAM[0..2]=41,2A,0B, o_err_code=0, o_cycle_cnt=4.
REQ-040 Stream 00 61 74 ... -> DONE on third byte, code 1, no BRAM writes, o_cpu_rst_n never high.
REQ-041 ADDR_W=3, 4 magic + 9 payload bytes without last -> 8 writes (addr 0..7), code 2, s_ready low after 8th payload byte.
REQ-042 i_stack_exceed and i_cpu_finish asserted same RUN cycle -> code 4.
REQ-043 TIMEOUT=20, no core events -> code 6, o_cycle_cnt=19, DONE after exactly 20 RUN cycles.
REQ-044 s_valid toggled randomly during LOAD, rst_n pulsed mid-LOAD, then full re-run -> outputs reset per REQ-037, second run completes code 0.
